exmem_stage_reg: RTL and testbench



---
 rtl/core_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 68 ++++++
 rtl/exmem_stage_reg.sv | 150 +++++++++++++++
 tb/tb_exmem_stage_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : core_pkg                                                   |
// | Brief    : Shared encodings and defaults for the five-stage RV core.  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_LDRR = 2'b01,
        MEM_LDRI = 2'b10,
        MEM_ST   = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    // Reserved size encoding behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return (size == SZ_W) || (size == SZ_RSV);
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mem_lane_align                                             |
// | Brief    : Effective address, byte enables, store-lane replication    |
// |            and misalignment detection (purely combinational).         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module mem_lane_align
    import core_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    localparam int BE_W = XLEN / 8
) (
    input  logic            valid_i,
    input  logic [1:0]      mem_i,
    input  logic [1:0]      size_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] addr_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [BE_W-1:0] be_o,
    output logic            misaligned_o
);

    logic [XLEN-1:0] w_offset;

    always_comb begin
        w_offset = (mem_i == MEM_LDRR) ? rs2_data_i : imm_i;
        addr_o   = rs1_data_i + w_offset;
    end

    // Only the four low lanes are ever enabled, even for wider XLEN.
    always_comb begin
        be_o = '0;
        if (mem_i != MEM_NONE) begin
            case (size_i)
                SZ_B:    be_o[3:0] = 4'b0001 << addr_o[1:0];
                SZ_H:    be_o[3:0] = addr_o[1] ? 4'b1100 : 4'b0011;
                default: be_o[3:0] = 4'b1111;
            endcase
        end
    end

    always_comb begin
        wdata_o = rs2_data_i;
        for (int i = 0; i < BE_W; i++) begin
            if (size_i == SZ_B) begin
                wdata_o[8*i +: 8] = rs2_data_i[7:0];
            end else if (size_i == SZ_H) begin
                wdata_o[8*i +: 8] = rs2_data_i[8*(i%2) +: 8];
            end
        end
    end

    always_comb begin
        misaligned_o = 1'b0;
        if (valid_i && (mem_i != MEM_NONE)) begin
            if (size_i == SZ_H) begin
                misaligned_o = addr_o[0];
            end else if (is_word(size_i)) begin
                misaligned_o = (addr_o[1:0] != 2'b00);
            end
        end
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/exmem_stage_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : exmem_stage_reg                                            |
// | Brief    : EX/MEM pipeline register with stall, flush, byte-lane      |
// |            alignment and misaligned-access squashing.                 |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module exmem_stage_reg
    import core_pkg::*;
#(
    parameter  int XLEN    = XLEN_DEFAULT,
    parameter  int RADDR_W = 5,
    localparam int BE_W    = XLEN / 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic               WB_i,
    input  logic [1:0]         Mem_i,
    input  logic [1:0]         size_i,
    input  logic [XLEN-1:0]    ALUres_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    output logic               valid_o,
    output logic               WB_o,
    output logic [1:0]         Mem_o,
    output logic [XLEN-1:0]    Memaddr_o,
    output logic [XLEN-1:0]    Memdata_o,
    output logic [XLEN-1:0]    ALUres_o,
    output logic [BE_W-1:0]    be_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               misaligned_o,
    output logic [15:0]        stall_cnt_o
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [XLEN-1:0] w_addr;
    logic [XLEN-1:0] w_wdata;
    logic [BE_W-1:0] w_be;
    logic            w_mis;
    logic            w_ok;

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .valid_i      (valid_i),
        .mem_i        (Mem_i),
        .size_i       (size_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .imm_i        (imm_i),
        .addr_o       (w_addr),
        .wdata_o      (w_wdata),
        .be_o         (w_be),
        .misaligned_o (w_mis)
    );

    logic               valid_d,     valid_q;
    logic               wb_d,        wb_q;
    logic [1:0]         mem_d,       mem_q;
    logic [XLEN-1:0]    memaddr_d,   memaddr_q;
    logic [XLEN-1:0]    memdata_d,   memdata_q;
    logic [XLEN-1:0]    alures_d,    alures_q;
    logic [BE_W-1:0]    be_d,        be_q;
    logic [RADDR_W-1:0] rd_addr_d,   rd_addr_q;
    logic               mis_d,       mis_q;
    logic [15:0]        stall_cnt_d, stall_cnt_q;

    // A valid, aligned instruction is the only case that propagates controls.
    assign w_ok = valid_i && !w_mis;

    always_comb begin
        valid_d     = valid_q;
        wb_d        = wb_q;
        mem_d       = mem_q;
        memaddr_d   = memaddr_q;
        memdata_d   = memdata_q;
        alures_d    = alures_q;
        be_d        = be_q;
        rd_addr_d   = rd_addr_q;
        mis_d       = mis_q;
        stall_cnt_d = stall_cnt_q;

        if (flush_i) begin
            valid_d = 1'b0;
            wb_d    = 1'b0;
            mem_d   = MEM_NONE;
            be_d    = '0;
            mis_d   = 1'b0;
        end else if (stall_i) begin
            if (valid_q && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else begin
            memaddr_d = w_addr;
            memdata_d = w_wdata;
            alures_d  = ALUres_i;
            rd_addr_d = rd_addr_i;
            valid_d   = valid_i;
            wb_d      = w_ok && WB_i;
            mem_d     = w_ok ? Mem_i : MEM_NONE;
            be_d      = w_ok ? w_be : '0;
            mis_d     = w_mis;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            wb_q        <= 1'b0;
            mem_q       <= MEM_NONE;
            memaddr_q   <= '0;
            memdata_q   <= '0;
            alures_q    <= '0;
            be_q        <= '0;
            rd_addr_q   <= '0;
            mis_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            wb_q        <= wb_d;
            mem_q       <= mem_d;
            memaddr_q   <= memaddr_d;
            memdata_q   <= memdata_d;
            alures_q    <= alures_d;
            be_q        <= be_d;
            rd_addr_q   <= rd_addr_d;
            mis_q       <= mis_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_o      = valid_q;
    assign WB_o         = wb_q;
    assign Mem_o        = mem_q;
    assign Memaddr_o    = memaddr_q;
    assign Memdata_o    = memdata_q;
    assign ALUres_o     = alures_q;
    assign be_o         = be_q;
    assign rd_addr_o    = rd_addr_q;
    assign misaligned_o = mis_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule : exmem_stage_reg
`default_nettype wire

// File: tb/tb_exmem_stage_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_exmem_stage_reg                                         |
// | Brief    : Randomised self-checking bench with a behavioural model.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_exmem_stage_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid, wb;
    logic [1:0]  mem, size;
    logic [31:0] alu, imm, rs1, rs2;
    logic [4:0]  rd;

    logic        valid_o, wb_o, mis_o;
    logic [1:0]  mem_o;
    logic [31:0] addr_o, data_o, alu_o;
    logic [3:0]  be_o;
    logic [4:0]  rd_o;
    logic [15:0] cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // Expected architectural state
    logic        e_valid, e_wb, e_mis;
    logic [1:0]  e_mem;
    logic [31:0] e_addr, e_data, e_alu;
    logic [3:0]  e_be;
    logic [4:0]  e_rd;
    int          e_cnt;

    always #5 clk = ~clk;

    exmem_stage_reg #(.XLEN(32), .RADDR_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .valid_i(valid), .WB_i(wb), .Mem_i(mem), .size_i(size),
        .ALUres_i(alu), .imm_i(imm), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .rd_addr_i(rd),
        .valid_o(valid_o), .WB_o(wb_o), .Mem_o(mem_o), .Memaddr_o(addr_o),
        .Memdata_o(data_o), .ALUres_o(alu_o), .be_o(be_o), .rd_addr_o(rd_o),
        .misaligned_o(mis_o), .stall_cnt_o(cnt_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural next-state from the rules, evaluated with the edge's inputs.
    task automatic model_edge();
        longint unsigned sum;
        int a, sz_bytes;
        logic bad;
        if (rst) begin
            e_valid = 0; e_wb = 0; e_mis = 0; e_mem = 0; e_be = 0;
            e_addr = 0; e_data = 0; e_alu = 0; e_rd = 0; e_cnt = 0;
        end else if (flush) begin
            e_valid = 0; e_wb = 0; e_mis = 0; e_mem = 0; e_be = 0;
        end else if (stall) begin
            if (e_valid && e_cnt < 65535) e_cnt = e_cnt + 1;
        end else begin
            sum = longint'(rs1) + longint'((mem == 2'd1) ? rs2 : imm);
            e_addr = 32'(sum % 64'h1_0000_0000);
            a = int'(e_addr % 4);
            sz_bytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            bad = valid && mem != 0 && (a % sz_bytes != 0);
            if (sz_bytes == 1)      e_data = 32'(rs2 % 256) * 32'h0101_0101;
            else if (sz_bytes == 2) e_data = 32'(rs2 % 65536) * 32'h0001_0001;
            else                    e_data = rs2;
            e_alu = alu;
            e_rd  = rd;
            e_valid = valid;
            e_mis = bad;
            if (!valid || bad) begin
                e_wb = 0; e_mem = 0; e_be = 0;
            end else begin
                e_wb  = wb;
                e_mem = mem;
                if (mem == 0)           e_be = 0;
                else if (sz_bytes == 1) e_be = 4'(1 << a);
                else if (sz_bytes == 2) e_be = 4'(3 << (a - a % 2));
                else                    e_be = 4'hF;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_val("valid",  valid_o, e_valid);
        check_val("wb",     wb_o,    e_wb);
        check_val("mem",    mem_o,   e_mem);
        check_val("addr",   addr_o,  e_addr);
        check_val("data",   data_o,  e_data);
        check_val("alu",    alu_o,   e_alu);
        check_val("be",     be_o,    e_be);
        check_val("rd",     rd_o,    e_rd);
        check_val("mis",    mis_o,   e_mis);
        check_val("cnt",    cnt_o,   64'(e_cnt));
    endtask

    task automatic randomize_inputs();
        valid = 1'($urandom);
        wb    = 1'($urandom);
        mem   = 2'($urandom);
        size  = 2'($urandom);
        alu   = $urandom;
        rd    = 5'($urandom);
        rs2   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        imm   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
        rs1   = ($urandom_range(0, 1) == 0) ? {$urandom_range(0, 255), 2'($urandom)} : $urandom;
    endtask

    task automatic set_op(input logic v, input logic [1:0] m, input logic [1:0] s,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        valid = v; wb = 1'b1; mem = m; size = s; rs1 = r1; rs2 = r2; imm = im;
        alu = $urandom; rd = 5'($urandom);
    endtask

    logic [31:0] snap_addr;
    int          snap_cnt;

    initial begin
        rst = 1; stall = 0; flush = 0;
        set_op(1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        e_cnt = 0;
        cycle();
        cycle();
        check_val("reset_valid", valid_o, 1'b0);
        check_val("reset_cnt",   cnt_o,   16'h0);
        rst = 0;

        set_op(1'b1, 2'b10, 2'b10, 32'h100, 32'h0, 32'h8);
        cycle();
        check_val("ld_addr", addr_o, 32'h108);
        check_val("ld_be",   be_o,   4'hF);
        check_val("ld_mis",  mis_o,  1'b0);

        set_op(1'b1, 2'b11, 2'b00, 32'h203, 32'hAB, 32'h0);
        cycle();
        check_val("sb_be",   be_o,   4'h8);
        check_val("sb_data", data_o, 32'hABAB_ABAB);

        set_op(1'b1, 2'b10, 2'b10, 32'h102, 32'h0, 32'h0);
        cycle();
        check_val("mis_flag", mis_o, 1'b1);
        check_val("mis_mem",  mem_o, 2'b00);
        check_val("mis_wb",   wb_o,  1'b0);
        check_val("mis_be",   be_o,  4'h0);

        set_op(1'b1, 2'b01, 2'b10, 32'h1000, 32'h10, 32'h55);
        cycle();
        check_val("rr_addr", addr_o, 32'h1010);
        set_op(1'b1, 2'b01, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h55);
        cycle();
        check_val("rr_wrap", addr_o, 32'h0);

        set_op(1'b1, 2'b10, 2'b10, 32'h400, 32'h0, 32'h4);
        cycle();
        snap_addr = addr_o;
        snap_cnt  = int'(cnt_o);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            cycle();
        end
        check_val("stall_hold", addr_o, 32'h404);
        check_val("stall_cnt3", cnt_o, 16'(snap_cnt + 3));
        flush = 1;
        cycle();
        check_val("sf_valid", valid_o, 1'b0);
        check_val("sf_cnt",   cnt_o, 16'(snap_cnt + 3));
        flush = 0; stall = 0;

        set_op(1'b1, 2'b11, 2'b01, 32'h802, 32'h1234_BEEF, 32'h0);
        cycle();
        check_val("sh_data", data_o, 32'hBEEF_BEEF);
        check_val("sh_be",   be_o,   4'hC);
        stall = 1;
        cycle();
        rst = 1;
        cycle();
        check_val("rst_stall_addr", addr_o, 32'h0);
        check_val("rst_stall_cnt",  cnt_o,  16'h0);
        rst = 0;
        cycle();
        check_val("rst_stall_nocnt", cnt_o, 16'h0);
        stall = 0;
        set_op(1'b1, 2'b10, 2'b00, 32'h31, 32'h0, 32'h2);
        cycle();
        check_val("post_rst_be", be_o, 4'h8);

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            rst   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 25);
            cycle();
        end
        rst = 0; flush = 0; stall = 0;

        set_op(1'b1, 2'b00, 2'b10, 32'h0, 32'h0, 32'h0);
        cycle();
        stall = 1;
        for (int i = 0; i < 65540; i++) begin
            randomize_inputs();
            cycle();
        end
        check_val("cnt_sat", cnt_o, 16'hFFFF);
        stall = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_exmem_stage_reg
`default_nettype wire
